// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and default bus address for the I2C target receiver
package i2c_pkg;
  localparam logic [6:0] DEFAULT_ADDR = 7'h42;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, STRETCH, DATA_ACK, IGNORE} state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: metastability synchronizer with level and single-cycle rise/fall strobes
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  // Reset to the idle-bus level so reset by itself never looks like an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= STAGES'({sync, din});
      prev <= sync[STAGES-1];
    end
  end
  assign level = sync[STAGES-1];
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target that ACKs its address, delivers bytes over valid/ready and stretches SCL on backpressure
module i2c_target_rx import i2c_pkg::*; #(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_ADDR,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_drive_low,
  output logic       sda_drive_low,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       stop_pulse,
  output logic       busy
);
  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
  logic start, stop;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n, rx_data_n, din_byte;
  logic pend, pend_n, rx_valid_n, scl_dl_n, sda_dl_n, stop_n;
  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl (.clk(clk), .rst(rst), .din(scl_in), .level(scl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda (.clk(clk), .rst(rst), .din(sda_in), .level(sda), .rise(sda_rise), .fall(sda_fall));
  assign start = scl & sda_fall;
  assign stop = scl & sda_rise;
  assign din_byte = {shreg[6:0], sda};
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      pend <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      scl_drive_low <= 1'b0;
      sda_drive_low <= 1'b0;
      stop_pulse <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shreg <= shreg_n;
      pend <= pend_n;
      rx_data <= rx_data_n;
      rx_valid <= rx_valid_n;
      scl_drive_low <= scl_dl_n;
      sda_drive_low <= sda_dl_n;
      stop_pulse <= stop_n;
    end
  end
  // pend marks a completed byte parked in shreg because rx_data was still occupied
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shreg_n = shreg;
    pend_n = pend;
    rx_data_n = rx_data;
    rx_valid_n = rx_valid & ~rx_ready;
    scl_dl_n = scl_drive_low;
    sda_dl_n = sda_drive_low;
    stop_n = 1'b0;
    if (start || stop) begin
      state_n = start ? ADDR : IDLE;
      cnt_n = '0;
      pend_n = 1'b0;
      scl_dl_n = 1'b0;
      sda_dl_n = 1'b0;
      stop_n = stop;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg_n = din_byte;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) state_n = (din_byte[7:1] == TARGET_ADDR && !din_byte[0]) ? ADDR_ACK : IGNORE;
        end
        ADDR_ACK: if (scl_fall) begin
          sda_dl_n = ~sda_drive_low;
          state_n = sda_drive_low ? DATA : ADDR_ACK;
          cnt_n = sda_drive_low ? 4'd0 : cnt;
        end
        DATA: begin
          if (scl_rise && cnt < 4'd8) begin
            shreg_n = din_byte;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              pend_n = rx_valid;
              rx_data_n = rx_valid ? rx_data : din_byte;
              rx_valid_n = rx_valid ? rx_valid_n : 1'b1;
            end
          end
          if (scl_fall && cnt == 4'd8) begin
            state_n = pend ? STRETCH : DATA_ACK;
            scl_dl_n = pend;
            sda_dl_n = ~pend;
          end
        end
        // Two steps: load and pull SDA once rx_data frees up, then let SCL go one clk later
        STRETCH: if (sda_drive_low) begin
          scl_dl_n = 1'b0;
          pend_n = 1'b0;
          state_n = DATA_ACK;
        end else if (!rx_valid) begin
          rx_data_n = shreg;
          rx_valid_n = 1'b1;
          sda_dl_n = 1'b1;
        end
        DATA_ACK: if (scl_fall) begin
          sda_dl_n = 1'b0;
          state_n = DATA;
          cnt_n = '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: bus-level master driving the target, with a scoreboard of bytes the target must deliver
module tb_i2c_target_rx;
  localparam int H = 8;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, rx_ready = 1'b0;
  logic scl_bus, sda_bus, scl_drive_low, sda_drive_low, rx_valid, stop_pulse, busy;
  logic [7:0] rx_data;
  assign scl_bus = scl_m & ~scl_drive_low;
  assign sda_bus = sda_m & ~sda_drive_low;

  i2c_target_rx #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_bus), .sda_in(sda_bus),
    .scl_drive_low(scl_drive_low), .sda_drive_low(sda_drive_low),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .stop_pulse(stop_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [7:0] exp_mem [64];
  int exp_wr = 0, exp_rd = 0;
  logic sel = 1'b0;
  int valid_run = 0, last_valid_run = 0, scl_run = 0, last_scl_run = 0, both_run = 0;
  int scl_cnt = 0, drv_cnt = 0, ovl_cnt = 0, stop_cnt = 0;
  logic prev_stop = 1'b0;
  int s0, s1, s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A target ACKs exactly a write to its own address
  function automatic logic exp_ack(input logic [7:0] a);
    return a[7:1] == 7'h42 && !a[0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (!scl_bus && t < 3000) begin
      tick(1);
      t++;
    end
    if (!scl_bus) check("scl_release_timeout", scl_bus, 1);
  endtask

  task automatic send_bit(input logic b);
    tick(2); sda_m = b; tick(H); scl_m = 1'b1; wait_scl_high(); tick(H); scl_m = 1'b0;
  endtask

  task automatic ack_slot(output logic a);
    tick(2); sda_m = 1'b1; tick(H); scl_m = 1'b1; wait_scl_high(); tick(H); a = sda_bus; scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_slot(a);
  endtask

  task automatic do_start();
    if (!scl_m) begin
      tick(2); sda_m = 1'b1; tick(H); scl_m = 1'b1; wait_scl_high();
    end
    tick(H); sda_m = 1'b0; tick(H); scl_m = 1'b0;
  endtask

  task automatic do_stop();
    tick(2); sda_m = 1'b0; tick(H); scl_m = 1'b1; wait_scl_high(); tick(H); sda_m = 1'b1; tick(H);
  endtask

  task automatic address(input logic [7:0] a);
    logic k;
    send_byte(a, k);
    sel = exp_ack(a);
    check("addr_ack", k, !sel);
  endtask

  task automatic data(input logic [7:0] b);
    logic k;
    if (sel) begin
      exp_mem[exp_wr] = b;
      exp_wr++;
    end
    send_byte(b, k);
    check("data_ack", k, !sel);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst) exp_rd = exp_wr;
        else begin
          if (rx_valid) begin
            if (exp_rd == exp_wr) check("rx_valid_spurious", rx_valid, 0);
            else begin
              check("rx_data", rx_data, exp_mem[exp_rd]);
              if (rx_ready) exp_rd++;
            end
          end
          if (rx_valid) valid_run++;
          else if (valid_run != 0) begin last_valid_run = valid_run; valid_run = 0; end
          if (scl_drive_low) scl_run++;
          else if (scl_run != 0) begin last_scl_run = scl_run; scl_run = 0; end
          scl_cnt += int'(scl_drive_low);
          drv_cnt += int'(scl_drive_low | sda_drive_low);
          if (sda_drive_low && scl_drive_low) both_run++;
          else if (both_run != 0) begin check("drive_overlap_len", both_run, 1); ovl_cnt++; both_run = 0; end
          if (stop_pulse) begin check("stop_pulse_width", prev_stop, 0); stop_cnt++; end
          prev_stop = stop_pulse;
        end
      end
    join_none

    tick(3);
    check("rst_scl_drive", scl_drive_low, 0);
    check("rst_sda_drive", sda_drive_low, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_stop_pulse", stop_pulse, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(5);

    // 0x42+W, 0xA5, consumer always ready: no stretch, one-clk valid
    rx_ready = 1'b1;
    s0 = scl_cnt; s1 = stop_cnt; s2 = ovl_cnt;
    do_start();
    check("busy_after_start", busy, 1);
    address(8'h84);
    data(8'hA5);
    do_stop();
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_valid_len", last_valid_run, 1);
    check("t1_no_stretch", scl_cnt - s0, 0);
    check("t1_no_overlap", ovl_cnt - s2, 0);
    check("t1_stop_cnt", stop_cnt - s1, 1);
    check("t1_busy_idle", busy, 0);
    check("t1_drained", exp_rd, exp_wr);

    // 0x43+W: wrong address, target stays silent
    do_start();
    s0 = drv_cnt; s1 = stop_cnt;
    address(8'h86);
    data(8'h5A);
    check("t2_busy", busy, 1);
    do_stop();
    check("t2_no_drive", drv_cnt - s0, 0);
    check("t2_stop_cnt", stop_cnt - s1, 1);
    check("t2_busy_idle", busy, 0);

    // 0x42+R: read not supported
    do_start();
    s0 = drv_cnt;
    address(8'h85);
    tick(50);
    check("t3_busy", busy, 1);
    do_stop();
    check("t3_no_drive", drv_cnt - s0, 0);
    check("t3_busy_idle", busy, 0);

    // Backpressure: 0x11 parks in rx_data, 0x22 stretches SCL for 500 clk
    rx_ready = 1'b0;
    s2 = ovl_cnt;
    do_start();
    address(8'h84);
    data(8'h11);
    check("t4_first_held", rx_data, 8'h11);
    fork
      data(8'h22);
      begin
        int t = 0;
        while (!scl_drive_low && t < 5000) begin tick(1); t++; end
        check("t4_stretch_seen", scl_drive_low, 1);
        tick(500);
        rx_ready = 1'b1;
      end
    join
    check("t4_stretch_len", last_scl_run, 503);
    check("t4_overlap_once", ovl_cnt - s2, 1);
    check("t4_rx_data", rx_data, 8'h22);
    do_stop();
    check("t4_drained", exp_rd, exp_wr);

    // Reset while stretching, then a clean transfer
    rx_ready = 1'b0;
    do_start();
    address(8'h84);
    data(8'h33);
    exp_mem[exp_wr] = 8'h44;
    exp_wr++;
    fork
      begin
        logic k;
        send_byte(8'h44, k);
        check("t5_nack_after_rst", k, 1);
      end
      begin
        int t = 0;
        while (!scl_drive_low && t < 5000) begin tick(1); t++; end
        check("t5_stretch_seen", scl_drive_low, 1);
        tick(20);
        rst = 1'b1;
        tick(1);
        check("t5_rst_scl", scl_drive_low, 0);
        check("t5_rst_sda", sda_drive_low, 0);
        check("t5_rst_valid", rx_valid, 0);
        check("t5_rst_busy", busy, 0);
        rst = 1'b0;
      end
    join
    do_start();
    address(8'h84);
    rx_ready = 1'b1;
    data(8'h55);
    do_stop();
    check("t5_rx_data", rx_data, 8'h55);

    // Repeated START in the middle of a byte
    rx_ready = 1'b0;
    do_start();
    address(8'h84);
    data(8'h66);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    do_start();
    check("t6_busy", busy, 1);
    check("t6_valid_kept", rx_valid, 1);
    check("t6_data_kept", rx_data, 8'h66);
    address(8'h84);
    rx_ready = 1'b1;
    tick(3);
    data(8'h77);
    do_stop();
    check("t6_rx_data", rx_data, 8'h77);
    check("all_delivered", exp_rd, exp_wr);
    check("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
